// File: rtl/add_seq_pkg.sv
// Shared constants and state encoding for the multi-word add/subtract sequencer.
package add_seq_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sixteen_adder.sv
// 16-bit ripple-style adder slice with carry in/out.
module sixteen_adder (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout
);

    // Full 17-bit sum so the carry falls out of the top bit.
    always_comb begin
        {Cout, S} = 17'(A) + 17'(B) + 17'(Cin);
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Time-shares one 16-bit adder to add/subtract NWORDS*16-bit operands, LSW first.
module multiword_add_seq
    import add_seq_pkg::*;
#(
    parameter int unsigned NWORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NWORDS*WORD_W-1:0]   in_a,
    input  logic [NWORDS*WORD_W-1:0]   in_b,
    input  logic                       in_cin,
    input  logic                       in_sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NWORDS*WORD_W-1:0]   out_sum,
    output logic                       out_cout,
    output logic                       out_ovf
);

    localparam int unsigned W     = NWORDS * WORD_W;
    localparam int unsigned CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]                 cnt_q;
    logic                             carry_q;
    logic [NWORDS-1:0][WORD_W-1:0]    a_q;
    logic [NWORDS-1:0][WORD_W-1:0]    b_q;
    logic [NWORDS-1:0][WORD_W-1:0]    sum_q;
    logic                             cout_q;
    logic                             ovf_q;
    logic                             valid_q;

    logic                             accept;
    logic                             step;
    logic                             last;
    logic                             release_res;

    logic [WORD_W-1:0]                slice_a;
    logic [WORD_W-1:0]                slice_b;
    logic [WORD_W-1:0]                slice_s;
    logic                             slice_co;

    // Request side is ready only while no operation is in flight.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

    assign slice_a = a_q[cnt_q];
    assign slice_b = b_q[cnt_q];

    sixteen_adder u_adder (
        .A    (slice_a),
        .B    (slice_b),
        .Cin  (carry_q),
        .S    (slice_s),
        .Cout (slice_co)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        step        = 1'b0;
        last        = 1'b0;
        release_res = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    release_res = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture; B is pre-inverted for subtraction.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= in_a;
            b_q <= in_b ^ {W{in_sub}};
        end
    end

    // Slice counter, carry chain and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q   <= '0;
                carry_q <= in_sub | in_cin;
            end
            if (step) begin
                sum_q[cnt_q] <= slice_s;
                carry_q      <= slice_co;
                cnt_q        <= cnt_q + CNT_W'(1);
            end
            if (last) begin
                cout_q  <= slice_co;
                ovf_q   <= (slice_a[WORD_W-1] == slice_b[WORD_W-1]) &&
                           (slice_s[WORD_W-1] != slice_a[WORD_W-1]);
                valid_q <= 1'b1;
            end
            if (release_res) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (NWORDS=4) against a wide-arithmetic model.
module tb_multiword_add_seq;

    localparam int unsigned NW = 4;
    localparam int unsigned W  = NW * 16;
    localparam int LAT_BUDGET  = 20;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int n_checks;
    int n_fail;

    multiword_add_seq #(.NWORDS(NW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-width arithmetic, signed overflow from operand/result signs.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub,
                                  output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] r;
        logic [W:0] cw;
        logic [W-1:0] bb;
        bb    = sub ? ~b : b;
        cw    = '0;
        cw[0] = sub ? 1'b1 : cin;
        r     = {1'b0, a} + {1'b0, bb} + cw;
        s     = r[W-1:0];
        co    = r[W];
        if (sub) ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        else     ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: v = '1;
            1: v = '0;
            2: v = {1'b1, {(W-1){1'b0}}};
            3: v = {1'b0, {(W-1){1'b1}}};
            default: ;
        endcase
        return v;
    endfunction

    // Drive one request (in_ready assumed high) and wait for out_valid; lat = edges after accept.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         output logic [W-1:0] s, output logic co, output logic ov,
                         output int lat);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        in_cin   = 1'($urandom);
        in_sub   = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < LAT_BUDGET) begin
            @(posedge clk); #1;
            lat++;
        end
        s  = out_sum;
        co = out_cout;
        ov = out_ovf;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum got=%h exp=0", out_sum); end
        n_checks++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL reset_out_cout got=%b exp=0", out_cout); end
        n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
    endtask

    task automatic test_directed();
        logic [W-1:0] a [5];
        logic [W-1:0] b [5];
        logic         ci [5];
        logic         sb [5];
        logic [W-1:0] es [5];
        logic         ec [5];
        logic         eo [5];
        logic [W-1:0] s;
        logic co, ov;
        int lat;
        a[0] = 64'h0000_0000_0000_9369; b[0] = 64'h0000_0000_0000_F7DE; ci[0] = 0; sb[0] = 0;
        es[0] = 64'h0000_0000_0001_8B47; ec[0] = 0; eo[0] = 0;
        a[1] = 64'hFFFF_FFFF_FFFF_FFFF; b[1] = 64'h0; ci[1] = 1; sb[1] = 0;
        es[1] = 64'h0; ec[1] = 1; eo[1] = 0;
        a[2] = 64'h5; b[2] = 64'h7; ci[2] = 0; sb[2] = 1;
        es[2] = 64'hFFFF_FFFF_FFFF_FFFE; ec[2] = 0; eo[2] = 0;
        a[3] = 64'h7FFF_FFFF_FFFF_FFFF; b[3] = 64'h1; ci[3] = 0; sb[3] = 0;
        es[3] = 64'h8000_0000_0000_0000; ec[3] = 0; eo[3] = 1;
        a[4] = 64'h8000_0000_0000_0000; b[4] = 64'h1; ci[4] = 0; sb[4] = 1;
        es[4] = 64'h7FFF_FFFF_FFFF_FFFF; ec[4] = 1; eo[4] = 1;
        for (int i = 0; i < 5; i++) begin
            issue(a[i], b[i], ci[i], sb[i], s, co, ov, lat);
            n_checks++; if (lat !== NW) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, NW); end
            n_checks++; if (s !== es[i]) begin n_fail++; $display("FAIL dir%0d_sum got=%h exp=%h", i, s, es[i]); end
            n_checks++; if (co !== ec[i]) begin n_fail++; $display("FAIL dir%0d_cout got=%b exp=%b", i, co, ec[i]); end
            n_checks++; if (ov !== eo[i]) begin n_fail++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ov, eo[i]); end
            drain();
            n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL dir%0d_release got in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s, es;
        logic ci, sb, co, ov, ec, eo;
        int lat;
        for (int i = 0; i < 30; i++) begin
            a  = rand_word();
            b  = rand_word();
            ci = 1'($urandom);
            sb = 1'($urandom);
            model(a, b, ci, sb, es, ec, eo);
            issue(a, b, ci, sb, s, co, ov, lat);
            n_checks++; if (lat !== NW) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, NW); end
            n_checks++; if (s !== es) begin n_fail++; $display("FAIL rnd%0d_sum a=%h b=%h cin=%b sub=%b got=%h exp=%h", i, a, b, ci, sb, s, es); end
            n_checks++; if (co !== ec) begin n_fail++; $display("FAIL rnd%0d_cout got=%b exp=%b", i, co, ec); end
            n_checks++; if (ov !== eo) begin n_fail++; $display("FAIL rnd%0d_ovf got=%b exp=%b", i, ov, eo); end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            drain();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s0, s1, es;
        logic co0, ov0, co1, ov1, ec, eo;
        int lat;
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, s0, co0, ov0, lat);
        for (int c = 0; c < 3; c++) begin
            in_valid = (c != 1);
            in_a     = {$urandom, $urandom};
            in_b     = {$urandom, $urandom};
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_valid got=%b exp=1", c, out_valid); end
            n_checks++; if (out_sum !== 64'h8000_0000_0000_0000 || out_cout !== 1'b0 || out_ovf !== 1'b1) begin
                n_fail++; $display("FAIL bp%0d_hold got sum=%h cout=%b ovf=%b exp sum=8000000000000000 cout=0 ovf=1", c, out_sum, out_cout, out_ovf);
            end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d_in_ready got=%b exp=0", c, in_ready); end
        end
        in_valid = 1'b0;
        drain();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
        model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, es, ec, eo);
        issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, s1, co1, ov1, lat);
        n_checks++; if (lat !== NW || s1 !== es || co1 !== ec || ov1 !== eo) begin
            n_fail++; $display("FAIL bp_second got lat=%0d sum=%h cout=%b ovf=%b exp lat=%0d sum=%h cout=%b ovf=%b", lat, s1, co1, ov1, NW, es, ec, eo);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] s;
        logic co, ov;
        int lat;
        int seen;
        in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'h1; in_cin = 1'b0; in_sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_sum !== '0) begin n_fail++; $display("FAIL rstmid_sum got=%h exp=0", out_sum); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_result got=%0d valid cycles exp=0", seen); end
        issue(64'h0000_0000_0000_9369, 64'h0000_0000_0000_F7DE, 1'b0, 1'b0, s, co, ov, lat);
        n_checks++; if (lat !== NW || s !== 64'h0000_0000_0001_8B47 || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_after got lat=%0d sum=%h cout=%b ovf=%b exp lat=4 sum=0000000000018b47 cout=0 ovf=0", lat, s, co, ov);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q_s [$];
        logic         q_c [$];
        logic         q_o [$];
        logic [W-1:0] es;
        logic ec, eo;
        int last_acc;
        int n_acc;
        int guard;
        last_acc  = -1;
        n_acc     = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 40 || q_s.size() != 0; cyc++) begin
            if (out_valid) begin
                n_checks++;
                if (q_s.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected_result sum=%h", out_sum);
                end else if (out_sum !== q_s[0] || out_cout !== q_c[0] || out_ovf !== q_o[0]) begin
                    n_fail++; $display("FAIL b2b_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b", out_sum, out_cout, out_ovf, q_s[0], q_c[0], q_o[0]);
                end
                if (q_s.size() != 0) begin
                    void'(q_s.pop_front()); void'(q_c.pop_front()); void'(q_o.pop_front());
                end
            end
            in_valid = (cyc < 40);
            in_a   = rand_word();
            in_b   = rand_word();
            in_cin = 1'($urandom);
            in_sub = 1'($urandom);
            if (in_valid && in_ready) begin
                model(in_a, in_b, in_cin, in_sub, es, ec, eo);
                q_s.push_back(es); q_c.push_back(ec); q_o.push_back(eo);
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc !== NW + 2) begin
                        n_fail++; $display("FAIL b2b_period got=%0d exp=%0d", cyc - last_acc, NW + 2);
                    end
                end
                last_acc = cyc;
                n_acc++;
            end
            @(posedge clk); #1;
            guard = cyc;
            if (guard > 200) break;
        end
        n_checks++; if (q_s.size() !== 0 || n_acc < 5) begin
            n_fail++; $display("FAIL b2b_drain got pending=%0d accepts=%0d exp pending=0 accepts>=5", q_s.size(), n_acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
